mips_multi_ctrl: RTL
====================

Name: mips_multi_ctrl

Overview:
Multicycle MIPS control unit: a Moore main FSM plus an ALU decoder. Sits directly upstream of the program-counter register and drives its write enable (pc_en) and next-PC mux select (pc_src). Also drives IR load, memory, register-file and ALU mux controls for the datapath. Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

Parameters:
OPW, 6, opcode field width
FNW, 6, funct field width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
op  in  OPW  instr[31:26] from instruction register
funct  in  FNW  instr[5:0] from instruction register
zero  in  1  ALU zero flag, current cycle
pc_en  out  1  PC register enable = pc_write | (branch & zero)
pc_src  out  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target
iord  out  1  memory address select: 0 PC, 1 ALUOut
mem_write  out  1  data memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  write-register select: 0 rt, 1 rd
mem_to_reg  out  1  write-data select: 0 ALUOut, 1 memory data
reg_write  out  1  register file write enable
alu_src_a  out  1  0 PC, 1 register A
alu_src_b  out  2  00 register B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2
alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
state  out  4  current state, debug only

Behaviour:
- State register 4 bits. Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Reset: on a rising clk edge with reset=1, state <= FETCH.
- While reset=1, pc_en, ir_write, mem_write and reg_write are forced 0, combinationally, regardless of state.
- Other outputs always follow the state decode.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op: 0x23/0x2B->MEMADR, 0x00->EXEC, 0x04->BRANCH, 0x08->ADDIEX, 0x02->JUMP, any other opcode->FETCH (executes as a nop).
  - MEMADR: op 0x23->MEMRD, otherwise->MEMWR.
  - MEMRD->MEMWB.
  - EXEC->ALUWB.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
  - Encodings 12-15->FETCH, with all outputs 0 in that cycle.
- Moore outputs. Any signal not listed for a state is 0.
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_src=00, ir_write=1, pc_write=1.
  - DECODE: alu_src_a=0, alu_src_b=11, aluop=00.
  - MEMADR, ADDIEX: alu_src_a=1, alu_src_b=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - MEMWR: iord=1, mem_write=1.
  - EXEC: alu_src_a=1, alu_src_b=00, aluop=10.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, aluop=01, pc_src=01, branch=1.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - JUMP: pc_src=10, pc_write=1.
- pc_en is combinational from state and zero, with no register stage. In BRANCH, pc_en=zero in the same cycle.
- ALU decoder (combinational, internal 2-bit aluop):
  - aluop 00->010.
  - aluop 01->110.
  - aluop 10 by funct: 0x20->010, 0x22->110, 0x24->000, 0x25->001, 0x2A->111, any other->010.
- Cycles per instruction, counted from the FETCH cycle: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
- op and funct are sampled only in DECODE, MEMADR and EXEC. They must be stable from the IR load onward; the IR holds them.
- Reset asserted mid-instruction (any state): the next edge goes to FETCH. No write strobe is asserted while reset=1.

Test Plan:
- Reset: hold reset=1 for 3 cycles with op=0x23 -> state=0, and pc_en=ir_write=mem_write=reg_write=0 throughout. Release reset -> first cycle shows pc_en=1, ir_write=1, alu_src_b=01, alu_control=010.
- lw, op=0x23 -> states 0,1,2,3,4,0. Cycle 4: iord=1. Cycle 5: reg_write=1, mem_to_reg=1, reg_dst=0.
- sw, op=0x2B -> states 0,1,2,5,0. mem_write=1 only in state 5, with iord=1.
- R-type, op=0x00: funct=0x22 -> EXEC gives alu_control=110. Repeat with funct=0x2A -> 111. Both end in ALUWB with reg_write=1, reg_dst=1.
- beq, op=0x04: zero=1 in BRANCH -> pc_en=1, pc_src=01. Repeat with zero=0 -> pc_en=0. Both return to FETCH.
- j, op=0x02 -> JUMP shows pc_en=1, pc_src=10. Then:
  - op=0x3F -> 0,1,0 with no write strobes in DECODE.
  - Assert reset during MEMRD -> state=0 next edge.

Source files
------------

// File: rtl/mips_multi_ctrl.sv
// Multicycle MIPS control: Moore main FSM plus ALU decoder.
// Drives the PC enable/select, memory, IR, register-file and ALU controls.
module mips_multi_ctrl #(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  output logic           pc_en,
  output logic [1:0]     pc_src,
  output logic           iord,
  output logic           mem_write,
  output logic           ir_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [2:0]     alu_control,
  output logic [3:0]     state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] aluop;
  } ctrl_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'h00);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'h02);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'h04);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'h08);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'h23);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'h2B);

  localparam logic [FNW-1:0] FN_ADD = FNW'(6'h20);
  localparam logic [FNW-1:0] FN_SUB = FNW'(6'h22);
  localparam logic [FNW-1:0] FN_AND = FNW'(6'h24);
  localparam logic [FNW-1:0] FN_OR  = FNW'(6'h25);
  localparam logic [FNW-1:0] FN_SLT = FNW'(6'h2A);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Decode of the state about to be entered, so the registered
  // outputs line up with state_q as a pure Moore decode.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 2'b01;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.aluop     = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.aluop     = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_RTYPE)        state_d = S_EXEC;
        else if (op == OP_BEQ)          state_d = S_BRANCH;
        else if (op == OP_ADDI)         state_d = S_ADDIEX;
        else if (op == OP_J)            state_d = S_JUMP;
        else                            state_d = S_FETCH;
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
    ctrl_d = decode(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    alu_control = 3'b010;
    case (ctrl_q.aluop)
      2'b00: alu_control = 3'b010;
      2'b01: alu_control = 3'b110;
      default: begin
        if (funct == FN_ADD)      alu_control = 3'b010;
        else if (funct == FN_SUB) alu_control = 3'b110;
        else if (funct == FN_AND) alu_control = 3'b000;
        else if (funct == FN_OR)  alu_control = 3'b001;
        else if (funct == FN_SLT) alu_control = 3'b111;
        else                      alu_control = 3'b010;
      end
    endcase
  end

  // Strobes are gated by reset directly so nothing writes while it is held.
  assign pc_en      = ~reset & (ctrl_q.pc_write | (ctrl_q.branch & zero));
  assign ir_write   = ~reset & ctrl_q.ir_write;
  assign mem_write  = ~reset & ctrl_q.mem_write;
  assign reg_write  = ~reset & ctrl_q.reg_write;
  assign pc_src     = ctrl_q.pc_src;
  assign iord       = ctrl_q.iord;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign state      = state_q;

endmodule
